// File: rtl/lookup_bv_param.sv
// Bit-vector classification table: 2^KEY_W entries of {valid, 2^RULE_W-bit rule vector}.
// Port A serves a fully pipelined lookup path with 2-cycle latency. Port B is shared by the
// post-reset init sweep and a read-modify-write update FSM with a ready/done handshake.
// A port-B write landing on the same edge a lookup is sampled is forwarded into the lookup.
module lookup_bv_param #(
    parameter int KEY_W  = 8,
    parameter int RULE_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [KEY_W-1:0]         key,
    output logic                     bv_valid,
    output logic [(1<<RULE_W)-1:0]   bv,
    output logic                     hit,
    input  logic                     set_valid,
    input  logic [1:0]               set_op,
    input  logic [KEY_W-1:0]         set_key,
    input  logic [RULE_W-1:0]        set_rule,
    output logic                     set_ready,
    output logic                     set_done,
    output logic                     init_done
);

    localparam int BV_W  = 1 << RULE_W;
    localparam int DEPTH = 1 << KEY_W;
    localparam int ENT_W = BV_W + 1;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_DEL = 2'b10;

    typedef enum logic [1:0] {INIT, IDLE, MOD, WR} state_t;

    state_t             state, state_nx;
    logic [KEY_W-1:0]   cnt, cnt_nx;
    logic               init_done_nx;
    logic               capture;

    logic [1:0]         op_r;
    logic [KEY_W-1:0]   key_r;
    logic [RULE_W-1:0]  rule_r;
    logic [ENT_W-1:0]   new_r;

    logic [BV_W-1:0]    mask;
    logic [BV_W-1:0]    old_vec;

    logic               wr_en;
    logic [KEY_W-1:0]   wr_addr;
    logic [ENT_W-1:0]   wr_data;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   q_a;
    logic [ENT_W-1:0]   q_b;

    logic               v1, ok1, fwd1;
    logic [ENT_W-1:0]   fwd_d1;
    logic               v2, ok2;
    logic [ENT_W-1:0]   e2;

    // FSM state, sweep counter and init flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            init_done <= init_done_nx;
        end
    end

    // Next state, port-B write control and handshake outputs
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        init_done_nx = init_done;
        capture      = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = key_r;
        wr_data      = new_r;
        set_ready    = 1'b0;
        set_done     = 1'b0;
        case (state)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = cnt;
                wr_data = '0;
                cnt_nx  = cnt + KEY_W'(1);
                if (cnt == '1) begin
                    state_nx     = IDLE;
                    init_done_nx = 1'b1;
                end
            end
            IDLE: begin
                set_ready = 1'b1;
                if (set_valid) begin
                    capture  = 1'b1;
                    state_nx = MOD;
                end
            end
            MOD: begin
                state_nx = WR;
            end
            WR: begin
                set_done = 1'b1;
                wr_en    = (op_r != OP_NOP);
                state_nx = IDLE;
            end
            default: begin
                state_nx = INIT;
            end
        endcase
    end

    // Rule mask and old vector (an invalid entry counts as an empty vector)
    always_comb begin
        mask    = BV_W'(1) << rule_r;
        old_vec = q_b[BV_W] ? q_b[BV_W-1:0] : '0;
    end

    // Update request capture and new-entry formation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r   <= OP_NOP;
            key_r  <= '0;
            rule_r <= '0;
            new_r  <= '0;
        end else begin
            if (capture) begin
                op_r   <= set_op;
                key_r  <= set_key;
                rule_r <= set_rule;
            end
            if (state == MOD) begin
                case (op_r)
                    OP_ADD:  new_r <= {1'b1, old_vec | mask};
                    OP_DEL:  new_r <= {1'b1, old_vec & ~mask};
                    default: new_r <= '0;
                endcase
            end
        end
    end

    // Port B: update/sweep write and update read (contents are not reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (capture) begin
            q_b <= mem[set_key];
        end
    end

    // Port A: lookup read
    always_ff @(posedge clk) begin
        q_a <= mem[key];
    end

    // Lookup pipeline with same-edge write forwarding and init-time masking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1       <= 1'b0;
            ok1      <= 1'b0;
            fwd1     <= 1'b0;
            fwd_d1   <= '0;
            v2       <= 1'b0;
            ok2      <= 1'b0;
            e2       <= '0;
            bv_valid <= 1'b0;
            bv       <= '0;
            hit      <= 1'b0;
        end else begin
            v1       <= key_valid;
            ok1      <= init_done;
            fwd1     <= wr_en && (wr_addr == key);
            fwd_d1   <= wr_data;
            v2       <= v1;
            ok2      <= ok1;
            e2       <= fwd1 ? fwd_d1 : q_a;
            bv_valid <= v2;
            if (v2) begin
                if (ok2 && e2[BV_W]) begin
                    hit <= 1'b1;
                    bv  <= e2[BV_W-1:0];
                end else begin
                    hit <= 1'b0;
                    bv  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lookup_bv_param.sv
// Directed self-checking bench for lookup_bv_param (KEY_W=8, RULE_W=6).
module tb_lookup_bv_param;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [7:0]  key;
    logic        bv_valid;
    logic [63:0] bv;
    logic        hit;
    logic        set_valid;
    logic [1:0]  set_op;
    logic [7:0]  set_key;
    logic [5:0]  set_rule;
    logic        set_ready;
    logic        set_done;
    logic        init_done;

    int n_cmp = 0;
    int n_bad = 0;

    lookup_bv_param #(.KEY_W(8), .RULE_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key       (key),
        .bv_valid  (bv_valid),
        .bv        (bv),
        .hit       (hit),
        .set_valid (set_valid),
        .set_op    (set_op),
        .set_key   (set_key),
        .set_rule  (set_rule),
        .set_ready (set_ready),
        .set_done  (set_done),
        .init_done (init_done)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  k;
        logic [5:0]  rule;
        logic        exp_hit;
        logic [63:0] exp_bv;
    } vec_t;

    vec_t vt[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_lookup(input logic [7:0] k, output logic [3:0] pat,
                             output logic h, output logic [63:0] b);
        key_valid = 1'b1;
        key       = k;
        h = 1'b0;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) key_valid = 1'b0;
            pat[3-i] = bv_valid;
            if (i == 2) begin
                h = hit;
                b = bv;
            end
        end
    endtask

    task automatic lookup_check(input string name, input logic [7:0] k,
                                input logic exp_h, input logic [63:0] exp_b);
        logic [3:0]  pat;
        logic        h;
        logic [63:0] b;
        do_lookup(k, pat, h, b);
        check({name, "_latency"}, pat, 4'b0010);
        check({name, "_hit"}, h, exp_h);
        check({name, "_bv"}, b, exp_b);
    endtask

    task automatic do_update(input logic [1:0] op, input logic [7:0] k, input logic [5:0] r);
        int w;
        logic [2:0] p;
        w = 0;
        while (!set_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("upd_ready", set_ready, 1'b1);
        set_valid = 1'b1;
        set_op    = op;
        set_key   = k;
        set_rule  = r;
        @(negedge clk);
        set_valid = 1'b0;
        p[2] = set_done;
        @(negedge clk);
        p[1] = set_done;
        @(negedge clk);
        p[0] = set_done;
        check("upd_done_timing", p, 3'b010);
        check("upd_ready_after", set_ready, 1'b1);
    endtask

    // Called on the negedge where reset was released; probes one key during the sweep.
    task automatic wait_init(input logic [7:0] probe);
        int cyc;
        logic early;
        logic [3:0] pat;
        logic h;
        logic [63:0] b;
        early = 1'b0;
        do_lookup(probe, pat, h, b);
        check("init_probe_latency", pat, 4'b0010);
        check("init_probe_hit", h, 1'b0);
        check("init_probe_bv", b, 64'h0);
        cyc = 4;
        while (!init_done && cyc < 1000) begin
            if (set_ready) early = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("init_cycles", cyc, 256);
        check("ready_during_init", early, 1'b0);
        check("ready_after_init", set_ready, 1'b1);
    endtask

    initial begin
        int nvalid, first, nonzero;
        logic [3:0] pat;
        logic h;
        logic [63:0] b;
        logic [2:0] p;
        int ndone;

        vt[0] = '{2'b01, 8'h12, 6'd3,  1'b1, 64'h0000_0000_0000_0008};
        vt[1] = '{2'b01, 8'h12, 6'd63, 1'b1, 64'h8000_0000_0000_0008};
        vt[2] = '{2'b10, 8'h12, 6'd3,  1'b1, 64'h8000_0000_0000_0000};
        vt[3] = '{2'b11, 8'h12, 6'd9,  1'b0, 64'h0};
        vt[4] = '{2'b10, 8'h20, 6'd5,  1'b1, 64'h0};
        vt[5] = '{2'b01, 8'h20, 6'd5,  1'b1, 64'h0000_0000_0000_0020};
        vt[6] = '{2'b01, 8'h20, 6'd5,  1'b1, 64'h0000_0000_0000_0020};
        vt[7] = '{2'b00, 8'h20, 6'd7,  1'b1, 64'h0000_0000_0000_0020};
        vt[8] = '{2'b01, 8'hFF, 6'd31, 1'b1, 64'h0000_0000_8000_0000};
        vt[9] = '{2'b01, 8'h00, 6'd0,  1'b1, 64'h0000_0000_0000_0001};

        reset     = 1'b0;
        key_valid = 1'b0;
        key       = '0;
        set_valid = 1'b0;
        set_op    = '0;
        set_key   = '0;
        set_rule  = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", {bv_valid, hit, set_ready, set_done, init_done}, 5'b0);
        check("reset_bv", bv, 64'h0);
        reset = 1'b1;
        wait_init(8'h05);

        // Back-to-back lookups over the whole empty table
        nvalid = 0; first = -1; nonzero = 0;
        for (int i = 0; i < 260; i++) begin
            if (bv_valid) begin
                nvalid++;
                if (first < 0) first = i;
                if (hit || bv != 64'h0) nonzero++;
            end
            key_valid = (i < 256);
            key       = i[7:0];
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("sweep_pulses", nvalid, 256);
        check("sweep_first_latency", first, 3);
        check("sweep_nonzero", nonzero, 0);

        // Table-driven updates, each followed by a lookup of the same key
        for (int i = 0; i < 10; i++) begin
            do_update(vt[i].op, vt[i].k, vt[i].rule);
            lookup_check("vec", vt[i].k, vt[i].exp_hit, vt[i].exp_bv);
        end
        lookup_check("neighbour_untouched", 8'h21, 1'b0, 64'h0);

        // Lookups one cycle before and exactly on the write edge of add 0x40 rule 0
        set_valid = 1'b1; set_op = 2'b01; set_key = 8'h40; set_rule = 6'd0;
        @(negedge clk);
        set_valid = 1'b0;
        key_valid = 1'b1; key = 8'h40;
        @(negedge clk);
        check("fwd_done", set_done, 1'b1);
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        check("fwd_early_valid", bv_valid, 1'b1);
        check("fwd_early", {hit, bv}, {1'b0, 64'h0});
        @(negedge clk);
        check("fwd_same_valid", bv_valid, 1'b1);
        check("fwd_same", {hit, bv}, {1'b1, 64'h1});
        @(negedge clk);
        check("fwd_hold_valid", bv_valid, 1'b0);
        check("fwd_hold", {hit, bv}, {1'b1, 64'h1});

        // Async reset while an add of 0x33 sits in MOD
        lookup_check("pre_reset", 8'hFF, 1'b1, 64'h0000_0000_8000_0000);
        set_valid = 1'b1; set_op = 2'b01; set_key = 8'h33; set_rule = 6'd2;
        @(negedge clk);
        set_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midreset_outputs", {bv_valid, hit, set_ready, set_done, init_done}, 5'b0);
        check("midreset_bv", bv, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        wait_init(8'hFF);
        lookup_check("after_reset_33", 8'h33, 1'b0, 64'h0);
        lookup_check("after_reset_ff", 8'hFF, 1'b0, 64'h0);

        // set_valid held through busy cycles: one update per acceptance
        ndone = 0;
        set_valid = 1'b1; set_op = 2'b10; set_key = 8'h50; set_rule = 6'd1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 5) set_valid = 1'b0;
            if (set_done) ndone++;
            p = {p[1:0], set_done};
        end
        check("held_done_count", ndone, 2);
        check("held_ready_end", set_ready, 1'b1);
        lookup_check("held_result", 8'h50, 1'b1, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lookup_bv_param.md
Name: lookup_bv_param

Overview:
Parametrised bit-vector lookup table for the extractor's per-field classification stage. A key indexes a 2^KEY_W-entry table; each entry holds a valid flag and a 2^RULE_W-bit rule vector. The block adds over the fixed 8-bit/64-rule generation:
- ready/done update handshake with add, delete and clear-entry ops;
- a post-reset init sweep;
- guaranteed lookup/update coherence via write forwarding.

Parameters:
KEY_W, 8, key width; table depth = 2^KEY_W
RULE_W, 6, rule-index width; BV_W = 2^RULE_W bits per vector

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
key_valid  in  1  lookup request, sampled each cycle
key  in  KEY_W  lookup address
bv_valid  out  1  lookup result valid, one cycle per request
bv  out  BV_W  rule vector of looked-up entry
hit  out  1  looked-up entry valid flag
set_valid  in  1  update request
set_op  in  2  00 nop, 01 add rule bit, 10 delete rule bit, 11 clear entry
set_key  in  KEY_W  entry to update
set_rule  in  RULE_W  rule number (bit index)
set_ready  out  1  update FSM can accept
set_done  out  1  one-cycle pulse in the update's write cycle
init_done  out  1  table sweep complete, stays high until reset

Behaviour:
- Reset (async, low): bv_valid=0, bv=0, hit=0, set_ready=0, set_done=0, init_done=0; FSM to INIT with sweep counter 0. Reset mid-update discards the update; the sweep restarts from 0.
- Storage: inferred dual-port RAM of 2^KEY_W x (1+BV_W), no reset on contents.
  - Port A: lookup read only.
  - Port B: update read/write.
  - Read latency: 1 cycle.
- INIT: writes {valid=0, vector=0} to addresses 0..2^KEY_W-1, one per cycle. After the last write: init_done=1, go to IDLE. Takes 2^KEY_W cycles after reset release.
- Lookup pipeline, independent of the FSM, fully pipelined (one request per cycle):
  - key_valid sampled at edge t -> bv_valid=1 for exactly the cycle after edge t+2.
  - hit = entry valid bit.
  - bv = vector if valid, else 0.
  - bv and hit hold their last values when bv_valid=0.
  - While init_done=0: results forced to bv=0, hit=0.
- Coherence: a lookup sampled at edge t reflects every update whose write occurs at or before edge t. If port B writes the same address at edge t, the write data is forwarded to the lookup output stage.
- Update FSM states: INIT, IDLE, MOD, WR.
  - set_ready=1 only in IDLE.
  - IDLE: set_valid=1 -> accept at edge t, capture op/key/rule, issue port-B read of set_key, go to MOD.
  - MOD (after edge t):
    - Form mask = 1<<set_rule.
    - add: new = {1, old|mask}.
    - del: new = {1, old&~mask}.
    - clear: new = {0, 0}.
    - An old entry with valid=0 is treated as vector 0.
    - Go to WR.
  - WR (after edge t+1): port-B write at edge t+2, except nop, which does not write. set_done=1 for this cycle for every op, nop included. Go to IDLE; set_ready=1 after edge t+2.
  - Throughput: one update per 3 cycles.
- set_valid while set_ready=0 is ignored, not queued. The source holds the request until it sees ready.
- Deleting a non-set bit or adding a set bit is legal. Either marks the entry valid.
- set_rule is always in range (RULE_W bits index BV_W exactly).
- A same-address lookup and update in the same cycle are legal; lookups are never stalled.

Test Plan:
- Reset release, KEY_W=8 -> set_ready=0 and init_done=0 for 256 cycles, then both 1. A lookup of key 0x05 during init -> bv=0, hit=0 exactly 2 cycles after the request.
- add key=0x12 rule=3, then add key=0x12 rule=63 -> each set_done 2 cycles after acceptance. Lookup 0x12 -> hit=1, bv=0x8000_0000_0000_0008.
- del key=0x12 rule=3 -> bv=0x8000_0000_0000_0000, hit=1. Then clear key=0x12 -> hit=0, bv=0.
- Back-to-back lookups every cycle on keys 0x00..0xFF after init -> 256 consecutive bv_valid pulses, all bv=0, hit=0, 2-cycle latency.
- add key=0x40 rule=0 with a lookup of 0x40 sampled on the write edge -> bv=0x1, hit=1. A lookup one cycle earlier -> bv=0, hit=0.
- Async reset asserted in MOD of an add key=0x33 -> outputs zero immediately; init restarts; key 0x33 reads hit=0 afterwards. Also: set_valid held during the busy cycles -> exactly one update performed per acceptance.
